uart_tx_buf: RTL and testbench

- Buffered UART transmitter for the sigma platform: the transmit-side counterpart of the UART receive path fed from the board pin.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serialises them 8N1, LSB first, onto a single line, e.g. the board's UART_RXD_OUT pin.
- Used by board-level test and debug logic to stream bytes to the host without CPU involvement.

---
 rtl/uart_tx_buf.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_buf.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// uart_tx_buf
//   Buffered UART transmitter. Bytes are accepted over a valid/ready
//   handshake into a circular FIFO and serialised 8N1, LSB first, onto a
//   single idle-high line. Back-to-back frames have no idle gap.
//
// Parameters
//   CLK_DIV      clock cycles per bit (2..65535)
//   FIFO_DEPTH   FIFO entries (power of two, >= 2)
//
// Ports
//   clk_i         system clock
//   arst_i        asynchronous active-high reset
//   tx_valid_i    byte on tx_data_i is offered
//   tx_data_i     byte to send
//   tx_ready_o    FIFO can accept a byte this cycle
//   tx_o          serial line, idle high, driven from a flop
//   busy_o        frame in progress
//   fifo_count_o  bytes buffered, excluding the byte being shifted
//
// Build option
//   UART_TX_PARITY_EN  inserts an even-parity bit between data and stop
//                      (frame becomes 11 bit times instead of 10).
//
// States
//   IDLE   | line high, waiting for a buffered byte
//   START  | start bit (0)
//   DATA   | data bits, shift[bit_idx], LSB first
//   PARITY | even parity of the data byte (UART_TX_PARITY_EN only)
//   STOP   | stop bit (1); pops the next byte straight into START if one waits

module uart_tx_buf #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic                          tx_valid_i,
    input  logic [7:0]                    tx_data_i,
    output logic                          tx_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t         state, state_next;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [7:0]     shift_q, shift_next;
    logic [2:0]     bit_idx, bit_next;
    logic [15:0]    baud_cnt, baud_next;
    logic           tx_q, tx_next;
    logic           push, pop;
    logic           fifo_empty;
    logic           baud_done;

    // Ready is decoded from the registered count only, so a pop on the same
    // edge never lets a push in while full.
    assign tx_ready_o   = (count != CW'(FIFO_DEPTH));
    assign push         = tx_valid_i && tx_ready_o;
    assign fifo_empty   = (count == '0);
    assign baud_done    = (baud_cnt == 16'd0);
    assign tx_o         = tx_q;
    assign busy_o       = (state != IDLE);
    assign fifo_count_o = count;

    always_comb begin
        state_next = state;
        shift_next = shift_q;
        bit_next   = bit_idx;
        tx_next    = tx_q;
        pop        = 1'b0;
        baud_next  = (state == IDLE) ? baud_cnt : baud_cnt - 16'd1;

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = START;
                    tx_next    = 1'b0;
                    baud_next  = DIV_M1;
                end
            end
            START: begin
                if (baud_done) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                    tx_next    = shift_q[0];
                    baud_next  = DIV_M1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = DIV_M1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = ^shift_q;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        tx_next  = shift_q[bit_idx + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                    baud_next  = DIV_M1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = START;
                        tx_next    = 1'b0;
                        baud_next  = DIV_M1;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                        baud_next  = 16'd0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                baud_next  = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= IDLE;
            shift_q  <= 8'd0;
            bit_idx  <= 3'd0;
            baud_cnt <= 16'd0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_next;
            shift_q  <= shift_next;
            bit_idx  <= bit_next;
            baud_cnt <= baud_next;
            tx_q     <= tx_next;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= tx_data_i;
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
module tb_uart_tx_buf;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * DIV;

    logic       clk = 1'b0;
    logic       arst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_line;
    logic       busy;
    logic [2:0] fifo_count;

    uart_tx_buf #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .tx_valid_i  (tx_valid),
        .tx_data_i   (tx_data),
        .tx_ready_o  (tx_ready),
        .tx_o        (tx_line),
        .busy_o      (busy),
        .fifo_count_o(fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int frames_done = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  stim_q[$];
    int          acc_cyc[$];
    int          start_log[$];
    logic [10:0] last_obs;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Offers stim_q bytes with valid held high; expected bytes enter the
    // scoreboard on the edge they are accepted.
    task automatic drive(input int max_cyc);
        logic took;
        for (int k = 0; k < max_cyc && stim_q.size() != 0; k++) begin
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = stim_q[0];
            took     = tx_ready;
            @(posedge clk);
            #1;
            if (took) begin
                exp_q.push_back(stim_q.pop_front());
                acc_cyc.push_back(cyc);
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(output int t, output int cnt_max);
        bit ok = 0;
        cnt_max = 0;
        t = cyc;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            #1;
            if (int'(fifo_count) > cnt_max) cnt_max = int'(fifo_count);
            if (!busy) begin
                ok = 1;
                t  = cyc;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_frames(input int target);
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (frames_done >= target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("frame_timeout", frames_done, target);
    endtask

    // Line monitor: decodes each frame from tx_o, checks every cycle of each
    // bit is stable, and compares the byte against the scoreboard head.
    initial begin
        logic [10:0] obs;
        logic [7:0]  exp_b;
        int          glitch;
        int          st;
        bit          abort;
        forever begin
            @(negedge clk);
            if (arst === 1'b0 && tx_line === 1'b0) begin
                st     = cyc;
                glitch = 0;
                abort  = 0;
                obs    = '1;
                chk("frame_expected", exp_q.size() != 0, 1);
                exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                for (int i = 0; i < FRAME; i++) begin
                    if (i > 0) @(negedge clk);
                    if (arst !== 1'b0) begin
                        abort = 1;
                        break;
                    end
                    if (i % DIV == 0) obs[i / DIV] = tx_line;
                    else if (tx_line !== obs[i / DIV]) glitch++;
                end
                if (!abort) begin
                    chk("start_bit", obs[0], 0);
                    chk("data_byte", obs[8:1], exp_b);
`ifdef UART_TX_PARITY_EN
                    chk("parity_bit", obs[9], ^exp_b);
`endif
                    chk("stop_bit", obs[FB-1], 1);
                    chk("bit_stable", glitch, 0);
                    last_obs = obs;
                    start_log.push_back(st);
                    frames_done++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, cmax, tgt, base, ones;

        arst     = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx_line, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_count", fifo_count, 0);
        @(negedge clk);
        arst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte: latency, frame length, count stays zero.
        stim_q.push_back(8'h55);
        drive(1);
        n = acc_cyc[$];
        chk("single_cnt_after_push", fifo_count, 1);
        chk("single_tx_before", tx_line, 1);
        @(posedge clk);
        #1;
        chk("single_tx_low_n1", tx_line, 0);
        chk("single_busy_n1", busy, 1);
        chk("single_cnt_n1", fifo_count, 0);
        wait_idle(t, cmax);
        chk("single_busy_len", t - n, FRAME + 1);
        chk("single_cnt_max", cmax, 0);
        wait_frames(1);

        // Back-to-back: second start exactly one frame after the first.
        tgt = frames_done + 2;
        stim_q.push_back(8'hA3);
        stim_q.push_back(8'h0F);
        drive(2);
        n = acc_cyc[$-1];
        chk("b2b_consecutive", acc_cyc[$] - n, 1);
        wait_idle(t, cmax);
        chk("b2b_busy_len", t - n, 2 * FRAME + 1);
        wait_frames(tgt);
        chk("b2b_period", start_log[$] - start_log[$-1], FRAME);
        repeat (3) @(negedge clk);

        // Full FIFO: DEPTH+1 accepts, then ready returns on the first stop.
        tgt  = frames_done + 6;
        base = acc_cyc.size();
        for (int i = 0; i < 6; i++) stim_q.push_back(8'h30 + 8'(i));
        drive(8);
        n = acc_cyc[base];
        chk("full_accepts", acc_cyc.size() - base, DEPTH + 1);
        chk("full_ready", tx_ready, 0);
        chk("full_count", fifo_count, DEPTH);
        drive(200);
        chk("full_reaccept_cyc", acc_cyc[$] - n, FRAME + 2);
        wait_frames(tgt);
        chk("full_sb_empty", exp_q.size(), 0);
        wait_idle(t, cmax);
        repeat (3) @(negedge clk);

        // Push and pop on the same edge at count 2, then wrap the pointers.
        tgt = frames_done + 12;
        stim_q.push_back(8'hC1);
        stim_q.push_back(8'hC2);
        stim_q.push_back(8'hC3);
        drive(3);
        n = acc_cyc[$-2];
        while (cyc < n + FRAME - 1) @(negedge clk);
        chk("simul_cnt_before", fifo_count, 2);
        stim_q.push_back(8'hC4);
        drive(1);
        chk("simul_push_cyc", acc_cyc[$] - n, FRAME + 1);
        chk("simul_cnt_after", fifo_count, 2);
        for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom_range(0, 255)));
        drive(1000);
        wait_frames(tgt);
        chk("wrap_sb_empty", exp_q.size(), 0);
        wait_idle(t, cmax);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 of 0x00 with three bytes queued.
        stim_q.push_back(8'h00);
        stim_q.push_back(8'h11);
        stim_q.push_back(8'h22);
        stim_q.push_back(8'h33);
        drive(4);
        n = acc_cyc[$-3];
        while (cyc < n + 18) @(negedge clk);
        chk("rst_mid_tx_before", tx_line, 0);
        chk("rst_mid_cnt_before", fifo_count, 3);
        arst = 1'b1;
        #1;
        chk("rst_mid_tx_async", tx_line, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cnt", fifo_count, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        arst = 1'b0;
        base = frames_done;
        ones = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_line === 1'b1) ones++;
        end
        chk("post_rst_line_high", ones, 100);
        chk("post_rst_cnt", fifo_count, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_no_frames", frames_done, base);

`ifdef UART_TX_PARITY_EN
        stim_q.push_back(8'h07);
        drive(1);
        n = acc_cyc[$];
        wait_idle(t, cmax);
        chk("par07_len", t - n, 45);
        wait_frames(base + 1);
        chk("par07_bit", last_obs[9], 1);
        stim_q.push_back(8'h03);
        drive(1);
        n = acc_cyc[$];
        wait_idle(t, cmax);
        chk("par03_len", t - n, 45);
        wait_frames(base + 2);
        chk("par03_bit", last_obs[9], 0);
`endif

        chk("final_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
